memory_sys_master: RTL and testbench

- Initiator for the system-side command bus of the memory controller. It drives cmd_valid_sys, we_sys, addr_sys and write data, and waits for ready_sys.
- A host side (testcase or a future bus bridge) pushes read/write requests into a small FIFO. The block issues them one at a time and returns a response for every request, read data included.
- Sits between the stimulus/host logic and the memory controller, in the position of the system agent.

---
 rtl/memory_sys_master_if.sv | 34 +++
 rtl/memory_sys_master.sv | 156 +++++++++++++++
 tb/tb_memory_sys_master.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_sys_master_if.sv
// Host request/response and system command bus bundle for memory_sys_master.
// The master modport is the initiator's view; slave is the host plus controller view.
interface memory_sys_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_we;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       cmd_valid_sys;
  logic       we_sys;
  logic [7:0] addr_sys;
  logic [7:0] data_sys_o;
  logic       data_sys_oe;
  logic [7:0] data_sys_i;
  logic       ready_sys;
  logic       busy;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, data_sys_i, ready_sys,
    output req_ready, rsp_valid, rsp_we, rsp_addr, rsp_rdata, rsp_err,
           cmd_valid_sys, we_sys, addr_sys, data_sys_o, data_sys_oe, busy
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, data_sys_i, ready_sys,
    input  req_ready, rsp_valid, rsp_we, rsp_addr, rsp_rdata, rsp_err,
           cmd_valid_sys, we_sys, addr_sys, data_sys_o, data_sys_oe, busy
  );
endinterface

// File: rtl/memory_sys_master.sv
// Request FIFO plus one-at-a-time command issuer; cmd_valid_sys 2 cycles after accept, response 1 cycle after ready_sys.
// req_ready drops when the FIFO is full; MEM_SYS_MASTER_STATS_EN adds saturating completion counters.
module memory_sys_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  memory_sys_master_if.master bus
`ifdef MEM_SYS_MASTER_STATS_EN
  ,
  output logic [15:0]         stat_wr_cnt,
  output logic [15:0]         stat_rd_cnt,
  output logic [7:0]          stat_to_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          issue, resp;

  assign bus.req_ready = (cnt_q != CW'(FIFO_DEPTH));
  assign push          = bus.req_valid && bus.req_ready;

  // Storage is not reset: flushing the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          cmd_d   = fifo_q[rd_ptr_q];
          tmo_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Completion takes priority over a timeout expiring on the same edge.
        if (bus.ready_sys) begin
          rdata_d = cmd_q.we ? 8'h00 : bus.data_sys_i;
          state_d = RESP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue = (state_q == ISSUE);
  assign resp  = (state_q == RESP);

  assign bus.cmd_valid_sys = issue;
  assign bus.we_sys        = issue && cmd_q.we;
  assign bus.addr_sys      = issue ? cmd_q.addr : 8'h00;
  assign bus.data_sys_o    = (issue && cmd_q.we) ? cmd_q.wdata : 8'h00;
  assign bus.data_sys_oe   = issue && cmd_q.we;

  assign bus.rsp_valid = resp;
  assign bus.rsp_we    = resp && cmd_q.we;
  assign bus.rsp_addr  = resp ? cmd_q.addr : 8'h00;
  assign bus.rsp_rdata = resp ? rdata_q : 8'h00;
  assign bus.rsp_err   = resp && err_q;
  assign bus.busy      = (cnt_q != '0) || (state_q != IDLE);

`ifdef MEM_SYS_MASTER_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;
  logic [7:0]  to_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      to_cnt_q <= '0;
    end else if (resp) begin
      if (err_q) begin
        if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
      end else if (cmd_q.we) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign stat_wr_cnt = wr_cnt_q;
  assign stat_rd_cnt = rd_cnt_q;
  assign stat_to_cnt = to_cnt_q;
`endif

endmodule

// File: tb/tb_memory_sys_master.sv
// Bench for memory_sys_master: scoreboard of expected responses plus a controller model with per-command ready timing.
module tb_memory_sys_master;
  logic clk;
  logic reset;

  memory_sys_master_if bus();

`ifdef MEM_SYS_MASTER_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt;
  logic [7:0]  stat_to_cnt;
  int          exp_wr, exp_rd, exp_to;
`endif

  memory_sys_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_SYS_MASTER_STATS_EN
    ,
    .stat_wr_cnt (stat_wr_cnt),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_to_cnt (stat_to_cnt)
`endif
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] rdata;
    logic       err;
    int         len;
  } exp_t;

  exp_t       sb[$];
  int         ctl_q[$];
  int         n_checks;
  int         n_err;
  logic [7:0] ref_mem [256];
  logic [7:0] ctl_mem [256];
  int         rdy_at;
  bit         stray;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Controller model: ready_sys in the rdy-th ISSUE cycle of each command (0 = never).
  initial begin
    int issue_cyc;
    int cur_rdy;
    issue_cyc = 0;
    cur_rdy   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        issue_cyc     = 0;
        bus.ready_sys = 1'b0;
        continue;
      end
      if (bus.cmd_valid_sys) begin
        issue_cyc++;
        if (issue_cyc == 1) cur_rdy = (ctl_q.size() != 0) ? ctl_q.pop_front() : 0;
      end else begin
        issue_cyc = 0;
      end
      if (bus.cmd_valid_sys && cur_rdy != 0 && issue_cyc == cur_rdy) begin
        bus.ready_sys  = 1'b1;
        bus.data_sys_i = ctl_mem[bus.addr_sys];
        if (bus.we_sys) ctl_mem[bus.addr_sys] = bus.data_sys_o;
      end else begin
        bus.ready_sys  = stray && !bus.cmd_valid_sys;
        bus.data_sys_i = 8'($urandom);
      end
    end
  end

  // Protocol and response monitor.
  int         cur_len, low_cnt;
  bit         seen_cmd, prev_cv, prev_rsp;
  logic [16:0] prev_cmd;
  exp_t       e;

  always @(negedge clk) begin
    if (!reset) begin
      cur_len  = 0;
      low_cnt  = 0;
      seen_cmd = 0;
      prev_cv  = 0;
      prev_rsp = 0;
    end else begin
      if (prev_rsp) check("rsp_pulse", 32'(bus.rsp_valid), 0);
      if (bus.cmd_valid_sys) begin
        if (!prev_cv) begin
          if (seen_cmd) check("cmd_gap", 32'(low_cnt >= 2), 1);
          seen_cmd = 1;
          cur_len  = 1;
        end else begin
          cur_len++;
          check("cmd_stable", 32'({bus.we_sys, bus.addr_sys, bus.data_sys_o}), 32'(prev_cmd));
        end
        prev_cmd = {bus.we_sys, bus.addr_sys, bus.data_sys_o};
        low_cnt  = 0;
      end else begin
        low_cnt++;
      end
      if (bus.cmd_valid_sys || bus.data_sys_oe)
        check("oe_rd", 32'(bus.data_sys_oe), 32'(bus.cmd_valid_sys & bus.we_sys));
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_we",    32'(bus.rsp_we),    32'(e.we));
          check("rsp_addr",  32'(bus.rsp_addr),  32'(e.addr));
          check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          check("rsp_err",   32'(bus.rsp_err),   32'(e.err));
          check("issue_len", 32'(cur_len),       32'(e.len));
`ifdef MEM_SYS_MASTER_STATS_EN
          if (e.err) exp_to++;
          else if (e.we) exp_wr++;
          else exp_rd++;
`endif
        end
      end
      prev_cv  = bus.cmd_valid_sys;
      prev_rsp = bus.rsp_valid;
    end
  end

  task automatic push_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata, output int waited);
    exp_t x;
    waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("push_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    x.we    = we;
    x.addr  = addr;
    x.err   = (rdy_at == 0 || rdy_at > 16);
    x.len   = x.err ? 16 : rdy_at;
    x.rdata = (we || x.err) ? 8'h00 : ref_mem[addr];
    if (we && !x.err) ref_mem[addr] = wdata;
    sb.push_back(x);
    ctl_q.push_back(rdy_at);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < 600), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    logic [7:0] a;
    int dly[3];
    n_checks = 0;
    n_err    = 0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i * 7 + 3);
      ctl_mem[i] = ref_mem[i];
    end
`ifdef MEM_SYS_MASTER_STATS_EN
    exp_wr = 0; exp_rd = 0; exp_to = 0;
`endif
    reset = 1'b0;
    stray = 1'b0;
    rdy_at = 4;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ready_sys = 1'b0; bus.data_sys_i = '0;

    #23;
    check("rst_cmd_valid", 32'(bus.cmd_valid_sys), 0);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_oe",        32'(bus.data_sys_oe), 0);
`ifdef MEM_SYS_MASTER_STATS_EN
    check("rst_stats", 32'({stat_wr_cnt, stat_rd_cnt, stat_to_cnt}), 0);
`endif
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back, plus accept-to-command latency.
    rdy_at = 4;
    push_req(1'b1, 8'h3C, 8'hA5, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_valid_sys && n < 10);
    check("lat_cmd", 32'(n), 2);
    push_req(1'b0, 8'h3C, 8'h00, w);
    drain();

    // Mixed traffic with different ready delays.
    dly[0] = 1; dly[1] = 2; dly[2] = 7;
    for (int k = 0; k < 3; k++) begin
      rdy_at = dly[k];
      a = 8'($urandom);
      push_req(1'b1, a, 8'($urandom), w);
      push_req(1'b0, a, 8'h00, w);
      push_req(1'b0, a ^ 8'h81, 8'h00, w);
      drain();
    end

    // FIFO full: all commands time out, 5 held before req_ready drops.
    rdy_at = 0;
    for (int k = 0; k < 5; k++) push_req(k[0], 8'(8'h50 + k), 8'(k), w);
    @(negedge clk);
    check("full_rdy", 32'(bus.req_ready), 0);
    push_req(1'b0, 8'h60, 8'h00, w);
    check("full_stall", 32'(w > 0), 1);
    drain();

    // Timeout followed by a normally completing command.
    rdy_at = 0;
    push_req(1'b0, 8'h10, 8'h00, w);
    rdy_at = 5;
    push_req(1'b0, 8'h20, 8'h00, w);
    drain();

    // Ready on the last allowed cycle wins; one cycle later is a timeout.
    rdy_at = 16;
    push_req(1'b1, 8'h44, 8'h99, w);
    push_req(1'b0, 8'h44, 8'h00, w);
    rdy_at = 17;
    push_req(1'b0, 8'h44, 8'h00, w);
    drain();

    // Stray ready while idle must not produce anything.
    stray = 1'b1;
    repeat (6) @(negedge clk);
    check("stray_busy", 32'(bus.busy), 0);
    stray = 1'b0;
    rdy_at = 3;
    push_req(1'b0, 8'h44, 8'h00, w);
    drain();

    // Reset in the middle of ISSUE with two requests queued.
    rdy_at = 10;
    push_req(1'b0, 8'h01, 8'h00, w);
    push_req(1'b0, 8'h02, 8'h00, w);
    push_req(1'b0, 8'h03, 8'h00, w);
    n = 0;
    while (!bus.cmd_valid_sys && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_issue", 32'(bus.cmd_valid_sys), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstm_cmd_valid", 32'(bus.cmd_valid_sys), 0);
    check("rstm_req_ready", 32'(bus.req_ready), 1);
    check("rstm_busy",      32'(bus.busy), 0);
    check("rstm_addr",      32'(bus.addr_sys), 0);
    check("rstm_rsp_valid", 32'(bus.rsp_valid), 0);
    sb.delete();
    ctl_q.delete();
`ifdef MEM_SYS_MASTER_STATS_EN
    check("rstm_stats", 32'({stat_wr_cnt, stat_rd_cnt, stat_to_cnt}), 0);
    exp_wr = 0; exp_rd = 0; exp_to = 0;
`endif
    @(negedge clk) reset = 1'b1;
    repeat (40) @(negedge clk);
    check("rstm_idle", 32'(bus.busy), 0);

    // Normal operation after reset.
    rdy_at = 2;
    push_req(1'b1, 8'h77, 8'h5E, w);
    push_req(1'b0, 8'h77, 8'h00, w);
    drain();

`ifdef MEM_SYS_MASTER_STATS_EN
    check("stat_wr", 32'(stat_wr_cnt), 32'(exp_wr));
    check("stat_rd", 32'(stat_rd_cnt), 32'(exp_rd));
    check("stat_to", 32'(stat_to_cnt), 32'(exp_to));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
